rdma_sq_ack_tracker: RTL and testbench
======================================

Name: rdma_sq_ack_tracker

Overview:
User-side initiator end of the per-vFPGA RDMA send-queue/ACK pair. It sits between vFPGA user logic and that region's SQ/ACK slot on the RDMA arbiter.
- Issues SQ entries toward the arbiter and tracks them in order.
- Matches returning ACKs to outstanding entries.
- Emits one completion per entry carrying status and round-trip latency.
- Enforces an outstanding-request limit and a head-of-line timeout.

Parameters:
SQ_W, 128, SQ entry width; QPN occupies bits [QPN_W-1:0]
QPN_W, 10, queue-pair number width
N_OUT, 16, max outstanding entries (power of two)
TAG_W, 8, completion tag width
TS_W, 24, timestamp/timeout counter width

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
s_cmd_valid/s_cmd_ready  in/out  1/1  user SQ command handshake
s_cmd_data  in  SQ_W  user SQ entry
m_sq_valid/m_sq_ready  out/in  1/1  SQ toward arbiter
m_sq_data  out  SQ_W  registered SQ entry
s_ack_valid/s_ack_ready  in/out  1/1  ACK from arbiter
s_ack_data  in  QPN_W+1  bit0 = is_nack, [QPN_W:1] = qpn
m_cpl_valid/m_cpl_ready  out/in  1/1  completion to user
m_cpl_data  out  TAG_W+2+TS_W  {tag, status[1:0], latency}
timeout_cycles  in  TS_W  head-of-line timeout; 0 = disabled
clear  in  1  single-cycle pulse; leaves HALT
outstanding  out  $clog2(N_OUT)+1  entries in flight
halted  out  1  high in HALT
err_spurious  out  1  sticky: ACK arrived with nothing outstanding

Behaviour:
- Reset:
  - all valids 0; outstanding 0; tag counter 0; timestamp counter 0.
  - halted 0; err_spurious 0; state RUN; tracking FIFO empty.
- Timestamp counter: free-running, increments every cycle, wraps mod 2^TS_W.
- Issue:
  - The SQ output register accepts a command when state == RUN, outstanding < N_OUT, and the register is empty or draining (m_sq_ready).
  - s_cmd_ready is that condition.
  - Latency is 1 cycle from s_cmd accept to m_sq_valid.
  - On accept, push {tag, qpn, timestamp} to the tracking FIFO. Tag increments mod 2^TAG_W.
- ACK path:
  - s_ack_ready = completion register empty or m_cpl_ready.
  - On ACK accept with FIFO non-empty, pop head and form a completion:
    - status 00 OK, or 01 NACK if is_nack;
    - status 10 MISMATCH if ack qpn != head qpn, which also enters HALT.
    - latency = (now - head_ts) mod 2^TS_W.
  - On ACK accept with FIFO empty: drop the ACK, set err_spurious, emit no completion.
- Timeout: if timeout_cycles != 0, FIFO non-empty, and (now - head_ts) >= timeout_cycles with no ACK accepted this cycle:
  - pop head; emit status 11 TIMEOUT, latency = age; enter HALT.
  - Requires the completion register to be free; otherwise retry next cycle.
- Simultaneous events:
  - ACK and timeout on the same head: ACK wins.
  - Push and pop in the same cycle: outstanding unchanged.
  - Only one completion per cycle.
- State machine:
  - RUN -> HALT on MISMATCH or TIMEOUT.
  - HALT: issue blocked; ACKs and timeouts still processed.
  - HALT + clear -> RUN: flush FIFO, set outstanding to 0. Tag counter, err_spurious and any pending m_sq/m_cpl beats are preserved.
  - clear in RUN is ignored.
- A pending m_sq beat is never withdrawn; valid holds until ready.
- Reset mid-operation: everything returns to reset values immediately; in-flight beats are lost.
- Age arithmetic is valid because the timeout bounds age below 2^TS_W. With timeout disabled, wrap-around can alias the reported latency; this is documented, not guarded.

Decomposition:
- Shared package: status codes (CPL_OK, CPL_NACK, CPL_MISMATCH, CPL_TIMEOUT), ACK field offsets, completion field layout, tracker entry struct.
- One sub-module: rdma_trk_fifo, a synchronous FIFO of depth N_OUT with head peek, push/pop, count and flush.

Test Plan:
- Issue 3 cmds (qpn 5), return 3 ACKs qpn 5, is_nack 0, 10 cycles later -> 3 completions, tags 0,1,2, status 00, latency 10/10/10 (±1 per pipeline convention); outstanding back to 0.
- Push 17 cmds with N_OUT=16 and no ACKs -> s_cmd_ready low after 16 accepts; one ACK frees one slot -> 17th accepted next cycle.
- timeout_cycles=50, no ACK -> completion status 11 at age 50, halted=1, s_cmd_ready=0; clear pulse -> halted=0, outstanding=0, issue resumes with next tag.
- ACK qpn 7 while head qpn 5 -> status 10, HALT; ACK with FIFO empty -> err_spurious=1, no completion.
- m_sq_ready and m_cpl_ready held low 20 cycles under load -> no beat loss or duplication, valid/data stable; ACK and timeout in the same cycle -> single OK completion.
- aresetn asserted with 4 outstanding -> all outputs reset immediately; next cmd gets tag 0.

Source files
------------

// File: rtl/rdma_sq_ack_tracker_pkg.sv
// Shared definitions for the RDMA send-queue / ACK tracker.
//   - completion status codes
//   - ACK word field offsets and completion word layout
//   - default field widths and the tracker entry layout
package rdma_sq_ack_tracker_pkg;

    typedef enum logic [1:0] {
        CPL_OK       = 2'b00,
        CPL_NACK     = 2'b01,
        CPL_MISMATCH = 2'b10,
        CPL_TIMEOUT  = 2'b11
    } cpl_status_e;

    typedef enum logic {
        StRun,
        StHalt
    } trk_state_e;

    // ACK word: bit 0 is_nack, qpn above it.
    localparam int unsigned ACK_NACK_BIT = 0;
    localparam int unsigned ACK_QPN_LSB  = 1;

    // Completion word: {tag, status, latency}, latency in the low bits.
    localparam int unsigned CPL_STATUS_W = 2;

    localparam int unsigned DEF_QPN_W = 10;
    localparam int unsigned DEF_TAG_W = 8;
    localparam int unsigned DEF_TS_W  = 24;

    // Tracker entry for the default widths; the top packs the same field
    // order {tag, qpn, ts} for whatever widths it is built with.
    typedef struct packed {
        logic [DEF_TAG_W-1:0] tag;
        logic [DEF_QPN_W-1:0] qpn;
        logic [DEF_TS_W-1:0]  ts;
    } trk_entry_t;

endpackage

// File: rtl/rdma_trk_fifo.sv
// In-order tracking FIFO for outstanding SQ entries.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   push_i/data     write an entry at the tail
//   pop_i           drop the head entry
//   flush_i         empty the FIFO (wins over push/pop)
//   head_o          current head entry (valid when !empty_o)
//   empty_o/full_o  occupancy flags; count_o number of entries held
module rdma_trk_fifo #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned DATA_W = 8,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    input  logic              flush_i,
    output logic [DATA_W-1:0] head_o,
    output logic              empty_o,
    output logic              full_o,
    output logic [CNT_W-1:0]  count_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // A push into a full FIFO is legal only when the head leaves in the
    // same cycle.
    assign do_push = push_i & (~full_o | pop_i);
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/rdma_sq_ack_tracker.sv
// User-side initiator for one vFPGA's RDMA SQ/ACK slot.
// Issues SQ entries through a one-deep output register, tracks them in
// order, matches returning ACKs to the oldest entry and emits one
// completion {tag, status, latency} per entry. A head-of-line timeout or a
// QPN mismatch halts issue until a clear pulse.
// Ports:
//   aclk, aresetn                      clock, asynchronous active-low reset
//   s_cmd_*                            user SQ command in
//   m_sq_*                             registered SQ entry to the arbiter
//   s_ack_*                            ACK from the arbiter {qpn, is_nack}
//   m_cpl_*                            registered completion to the user
//   timeout_cycles                     head age limit, 0 disables
//   clear                              leave HALT, flush tracking state
//   outstanding, halted, err_spurious  status
module rdma_sq_ack_tracker
    import rdma_sq_ack_tracker_pkg::*;
#(
    parameter int unsigned SQ_W  = 128,
    parameter int unsigned QPN_W = DEF_QPN_W,
    parameter int unsigned N_OUT = 16,
    parameter int unsigned TAG_W = DEF_TAG_W,
    parameter int unsigned TS_W  = DEF_TS_W
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic                        s_cmd_valid,
    output logic                        s_cmd_ready,
    input  logic [SQ_W-1:0]             s_cmd_data,
    output logic                        m_sq_valid,
    input  logic                        m_sq_ready,
    output logic [SQ_W-1:0]             m_sq_data,
    input  logic                        s_ack_valid,
    output logic                        s_ack_ready,
    input  logic [QPN_W:0]              s_ack_data,
    output logic                        m_cpl_valid,
    input  logic                        m_cpl_ready,
    output logic [TAG_W+2+TS_W-1:0]     m_cpl_data,
    input  logic [TS_W-1:0]             timeout_cycles,
    input  logic                        clear,
    output logic [$clog2(N_OUT):0]      outstanding,
    output logic                        halted,
    output logic                        err_spurious
);

    localparam int unsigned CNT_W = $clog2(N_OUT) + 1;
    localparam int unsigned ENT_W = TAG_W + QPN_W + TS_W;
    localparam int unsigned CPL_W = TAG_W + CPL_STATUS_W + TS_W;

    trk_state_e        state_q;
    logic [TS_W-1:0]   ts_q;
    logic [TAG_W-1:0]  tag_q;
    logic              sq_valid_q;
    logic [SQ_W-1:0]   sq_data_q;
    logic              cpl_valid_q;
    logic [CPL_W-1:0]  cpl_data_q;
    logic              err_q;

    logic              fifo_push, fifo_pop, fifo_flush;
    logic [ENT_W-1:0]  fifo_head;
    logic              fifo_empty, fifo_full;
    logic [CNT_W-1:0]  fifo_count;

    logic [TAG_W-1:0]  head_tag;
    logic [QPN_W-1:0]  head_qpn, ack_qpn, cmd_qpn;
    logic [TS_W-1:0]   head_ts, head_age;
    logic              ack_nack;
    logic              cmd_fire, ack_fire, ack_match, ack_spur, cpl_free;
    logic              to_fire, halt_evt;
    cpl_status_e       cpl_status;

    assign cmd_qpn  = s_cmd_data[QPN_W-1:0];
    assign ack_qpn  = s_ack_data[ACK_QPN_LSB +: QPN_W];
    assign ack_nack = s_ack_data[ACK_NACK_BIT];

    assign head_tag = fifo_head[ENT_W-1 -: TAG_W];
    assign head_qpn = fifo_head[TS_W +: QPN_W];
    assign head_ts  = fifo_head[TS_W-1:0];
    // Modular age is exact while the timeout keeps it below 2^TS_W.
    assign head_age = ts_q - head_ts;

    // The fifo count is the outstanding count, so "outstanding < N_OUT"
    // is simply "not full".
    assign s_cmd_ready = (state_q == StRun) & ~fifo_full & (~sq_valid_q | m_sq_ready);
    assign cmd_fire    = s_cmd_valid & s_cmd_ready;

    assign cpl_free    = ~cpl_valid_q | m_cpl_ready;
    assign s_ack_ready = cpl_free;
    assign ack_fire    = s_ack_valid & s_ack_ready;
    assign ack_match   = ack_fire & ~fifo_empty;
    assign ack_spur    = ack_fire & fifo_empty;

    // An accepted ACK always takes the head before the timeout can.
    assign to_fire = (timeout_cycles != '0) & ~fifo_empty & (head_age >= timeout_cycles)
                   & ~ack_fire & cpl_free;

    assign fifo_push  = cmd_fire;
    assign fifo_pop   = ack_match | to_fire;
    assign fifo_flush = (state_q == StHalt) & clear;

    always_comb begin
        cpl_status = CPL_TIMEOUT;
        if (ack_match) begin
            if (ack_qpn != head_qpn) begin
                cpl_status = CPL_MISMATCH;
            end else if (ack_nack) begin
                cpl_status = CPL_NACK;
            end else begin
                cpl_status = CPL_OK;
            end
        end
    end

    assign halt_evt = to_fire | (ack_match & (ack_qpn != head_qpn));

    rdma_trk_fifo #(
        .DEPTH  (N_OUT),
        .DATA_W (ENT_W)
    ) u_trk_fifo (
        .clk_i       (aclk),
        .rst_ni      (aresetn),
        .push_i      (fifo_push),
        .push_data_i ({tag_q, cmd_qpn, ts_q}),
        .pop_i       (fifo_pop),
        .flush_i     (fifo_flush),
        .head_o      (fifo_head),
        .empty_o     (fifo_empty),
        .full_o      (fifo_full),
        .count_o     (fifo_count)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ts_q  <= '0;
            tag_q <= '0;
            err_q <= 1'b0;
        end else begin
            ts_q <= ts_q + TS_W'(1);
            if (cmd_fire) tag_q <= tag_q + TAG_W'(1);
            if (ack_spur) err_q <= 1'b1;
        end
    end

    // SQ output register: a beat holds until the arbiter takes it.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            sq_valid_q <= 1'b0;
            sq_data_q  <= '0;
        end else if (cmd_fire) begin
            sq_valid_q <= 1'b1;
            sq_data_q  <= s_cmd_data;
        end else if (m_sq_ready) begin
            sq_valid_q <= 1'b0;
        end
    end

    // Completion register: a pop only happens when this register is free.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cpl_valid_q <= 1'b0;
            cpl_data_q  <= '0;
        end else if (fifo_pop) begin
            cpl_valid_q <= 1'b1;
            cpl_data_q  <= {head_tag, cpl_status, head_age};
        end else if (m_cpl_ready) begin
            cpl_valid_q <= 1'b0;
        end
    end

    // A halt event arriving with clear keeps the block halted.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= StRun;
        end else begin
            unique case (state_q)
                StRun:  if (halt_evt) state_q <= StHalt;
                StHalt: if (clear && !halt_evt) state_q <= StRun;
            endcase
        end
    end

    assign m_sq_valid   = sq_valid_q;
    assign m_sq_data    = sq_data_q;
    assign m_cpl_valid  = cpl_valid_q;
    assign m_cpl_data   = cpl_data_q;
    assign outstanding  = fifo_count;
    assign halted       = (state_q == StHalt);
    assign err_spurious = err_q;

endmodule

// File: tb/tb_rdma_sq_ack_tracker.sv
module tb_rdma_sq_ack_tracker;

    localparam int SQ_W  = 128;
    localparam int QPN_W = 10;
    localparam int N_OUT = 16;
    localparam int TAG_W = 8;
    localparam int TS_W  = 24;
    localparam int CPL_W = TAG_W + 2 + TS_W;

    logic              aclk = 1'b0;
    logic              aresetn;
    logic              s_cmd_valid, s_cmd_ready;
    logic [SQ_W-1:0]   s_cmd_data;
    logic              m_sq_valid, m_sq_ready;
    logic [SQ_W-1:0]   m_sq_data;
    logic              s_ack_valid, s_ack_ready;
    logic [QPN_W:0]    s_ack_data;
    logic              m_cpl_valid, m_cpl_ready;
    logic [CPL_W-1:0]  m_cpl_data;
    logic [TS_W-1:0]   timeout_cycles;
    logic              clear;
    logic [4:0]        outstanding;
    logic              halted, err_spurious;

    rdma_sq_ack_tracker #(
        .SQ_W  (SQ_W),
        .QPN_W (QPN_W),
        .N_OUT (N_OUT),
        .TAG_W (TAG_W),
        .TS_W  (TS_W)
    ) dut (
        .aclk           (aclk),
        .aresetn        (aresetn),
        .s_cmd_valid    (s_cmd_valid),
        .s_cmd_ready    (s_cmd_ready),
        .s_cmd_data     (s_cmd_data),
        .m_sq_valid     (m_sq_valid),
        .m_sq_ready     (m_sq_ready),
        .m_sq_data      (m_sq_data),
        .s_ack_valid    (s_ack_valid),
        .s_ack_ready    (s_ack_ready),
        .s_ack_data     (s_ack_data),
        .m_cpl_valid    (m_cpl_valid),
        .m_cpl_ready    (m_cpl_ready),
        .m_cpl_data     (m_cpl_data),
        .timeout_cycles (timeout_cycles),
        .clear          (clear),
        .outstanding    (outstanding),
        .halted         (halted),
        .err_spurious   (err_spurious)
    );

    always #5 aclk = ~aclk;

    int cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    typedef struct {
        int          tag;
        logic [9:0]  qpn;
        int          acc;
    } ent_t;

    int               n_pass = 0;
    int               n_total = 0;
    int               next_tag = 0;
    int               seq_n = 0;
    logic [CPL_W-1:0] cpl_q [$];
    logic [SQ_W-1:0]  sq_q [$];
    ent_t             model [$];
    logic [CPL_W-1:0] cpl_exp_m;
    logic [SQ_W-1:0]  sq_exp_m;

    function automatic logic [CPL_W-1:0] mk_cpl(input int tag, input int st, input int lat);
        return {TAG_W'(tag), 2'(st), TS_W'(lat)};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic cmd(input logic [9:0] qpn, output int acc);
        bit r;
        bit done;
        done = 0;
        acc = -1;
        seq_n++;
        s_cmd_data  = {118'(seq_n), qpn};
        s_cmd_valid = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge aclk);
            r = s_cmd_ready;
            @(posedge aclk);
            #1;
            if (r) done = 1;
        end
        s_cmd_valid = 1'b0;
        if (!done) begin
            n_total++;
            $display("FAIL cmd_accept_wait: got no s_cmd_ready expected accept within 200 cycles");
        end else begin
            acc = cyc;
            sq_q.push_back(s_cmd_data);
            model.push_back('{next_tag, qpn, cyc});
            next_tag = (next_tag + 1) % 256;
        end
    endtask

    // hand_lat >= 0 overrides the latency derived from the accept times.
    task automatic ack(input logic [9:0] qpn, input bit nack, input int hand_lat,
                       output int acc);
        bit   r;
        bit   done;
        ent_t e;
        int   st;
        done = 0;
        acc = -1;
        s_ack_data  = {qpn, nack};
        s_ack_valid = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge aclk);
            r = s_ack_ready;
            @(posedge aclk);
            #1;
            if (r) done = 1;
        end
        s_ack_valid = 1'b0;
        if (!done) begin
            n_total++;
            $display("FAIL ack_accept_wait: got no s_ack_ready expected accept within 200 cycles");
        end else begin
            acc = cyc;
            if (model.size() > 0) begin
                e  = model.pop_front();
                st = (e.qpn != qpn) ? 2 : (nack ? 1 : 0);
                cpl_q.push_back(mk_cpl(e.tag, st, (hand_lat >= 0) ? hand_lat : cyc - e.acc));
            end
        end
    endtask

    task automatic clear_pulse();
        clear = 1'b1;
        @(posedge aclk);
        #1;
        clear = 1'b0;
        model.delete();
    endtask

    // Scoreboard monitors: a beat transfers when valid and ready at an edge.
    always @(negedge aclk) begin
        if (aresetn) begin
            if (m_cpl_valid && m_cpl_ready) begin
                n_total++;
                if (cpl_q.size() == 0) begin
                    $display("FAIL cpl_unexpected: got %0h expected no completion", m_cpl_data);
                end else begin
                    cpl_exp_m = cpl_q.pop_front();
                    if (m_cpl_data !== cpl_exp_m)
                        $display("FAIL cpl_data: got %0h expected %0h", m_cpl_data, cpl_exp_m);
                    else n_pass++;
                end
            end
            if (m_sq_valid && m_sq_ready) begin
                n_total++;
                if (sq_q.size() == 0) begin
                    $display("FAIL sq_unexpected: got %0h expected no beat", m_sq_data);
                end else begin
                    sq_exp_m = sq_q.pop_front();
                    if (m_sq_data !== sq_exp_m)
                        $display("FAIL sq_data: got %0h expected %0h", m_sq_data, sq_exp_m);
                    else n_pass++;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int a, a2, x;
        logic [SQ_W-1:0]  sq_hold;
        logic [CPL_W-1:0] cpl_hold;

        aresetn = 1'b0;
        s_cmd_valid = 1'b0; s_cmd_data = '0;
        s_ack_valid = 1'b0; s_ack_data = '0;
        m_sq_ready = 1'b1;  m_cpl_ready = 1'b1;
        timeout_cycles = '0; clear = 1'b0;

        // Reset state
        repeat (3) @(negedge aclk);
        check("rst_valids", {m_sq_valid, m_cpl_valid}, 0);
        check("rst_outstanding", outstanding, 0);
        check("rst_flags", {halted, err_spurious}, 0);
        @(posedge aclk); #1;
        aresetn = 1'b1;
        repeat (2) @(posedge aclk); #1;

        // Three commands, three ACKs ten cycles later
        for (int i = 0; i < 3; i++) cmd(10'd5, a);
        check("out_after_3", outstanding, 3);
        repeat (7) @(posedge aclk); #1;
        for (int i = 0; i < 3; i++) ack(10'd5, 1'b0, 10, x);
        check("out_after_acks", outstanding, 0);

        // Outstanding limit
        for (int i = 0; i < N_OUT; i++) cmd(10'd1, a);
        @(negedge aclk);
        check("full_outstanding", outstanding, 16);
        check("full_cmd_ready", s_cmd_ready, 0);
        @(posedge aclk); #1;
        fork
            begin ack(10'd1, 1'b0, -1, x); end
            begin cmd(10'd1, a); end
        join
        check("full_release_next_cycle", a - x, 1);
        check("full_outstanding_after", outstanding, 16);
        for (int i = 0; i < N_OUT; i++) ack(10'd1, i == 3, -1, x);
        check("full_drained", outstanding, 0);

        // Head-of-line timeout, then clear
        timeout_cycles = 24'd50;
        cmd(10'd2, a);
        cmd(10'd2, a);
        begin
            ent_t e;
            e = model.pop_front();
            cpl_q.push_back(mk_cpl(e.tag, 3, 50));
        end
        repeat (48) @(posedge aclk); #1;
        check("to_not_yet_halted", halted, 0);
        @(posedge aclk); #1;
        timeout_cycles = '0;
        check("to_halted", halted, 1);
        check("to_cmd_ready", s_cmd_ready, 0);
        check("to_outstanding", outstanding, 1);
        clear_pulse();
        check("clr_halted", halted, 0);
        check("clr_outstanding", outstanding, 0);
        cmd(10'd3, a);
        ack(10'd3, 1'b0, -1, x);

        // QPN mismatch, then spurious ACK
        cmd(10'd5, a);
        ack(10'd7, 1'b0, -1, x);
        check("mm_halted", halted, 1);
        check("mm_no_err_yet", err_spurious, 0);
        ack(10'd7, 1'b0, -1, x);
        check("spur_err", err_spurious, 1);
        clear_pulse();
        check("mm_clr_halted", halted, 0);

        // Backpressure on both outputs
        cmd(10'd9, a);
        cmd(10'd9, a2);
        sq_hold = s_cmd_data;
        m_sq_ready = 1'b0;
        m_cpl_ready = 1'b0;
        ack(10'd9, 1'b0, -1, x);
        cpl_hold = cpl_q[cpl_q.size() - 1];
        fork
            begin cmd(10'd9, a); end
            begin ack(10'd9, 1'b0, -1, x); end
            begin
                for (int i = 0; i < 20; i++) begin
                    @(negedge aclk);
                    check("stall_hold", {m_sq_valid, m_cpl_valid, s_cmd_ready, s_ack_ready,
                                         m_sq_data == sq_hold, m_cpl_data == cpl_hold},
                          6'b110011);
                end
                @(posedge aclk); #1;
                m_sq_ready = 1'b1;
                m_cpl_ready = 1'b1;
            end
        join
        ack(10'd9, 1'b1, -1, x);

        // ACK and timeout on the same head: ACK wins
        timeout_cycles = 24'd20;
        cmd(10'd4, a);
        repeat (19) @(posedge aclk); #1;
        ack(10'd4, 1'b0, 20, x);
        repeat (3) @(posedge aclk); #1;
        check("tie_not_halted", halted, 0);
        timeout_cycles = '0;

        // Reset with four outstanding
        for (int i = 0; i < 4; i++) cmd(10'd6, a);
        @(posedge aclk); #1;
        check("pre_rst_outstanding", outstanding, 4);
        check("pre_rst_err", err_spurious, 1);
        aresetn = 1'b0;
        #1;
        check("mid_rst_outstanding", outstanding, 0);
        check("mid_rst_flags", {m_sq_valid, m_cpl_valid, halted, err_spurious}, 0);
        model.delete();
        next_tag = 0;
        repeat (2) @(posedge aclk); #1;
        aresetn = 1'b1;
        @(posedge aclk); #1;
        cmd(10'd6, a);
        ack(10'd6, 1'b0, -1, x);

        repeat (5) @(posedge aclk); #1;
        check("cpl_queue_empty", cpl_q.size(), 0);
        check("sq_queue_empty", sq_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
